// File: rtl/channel_scheduler_pkg.sv
// Shared types for the memory channel scheduler.
package channel_scheduler_pkg;

  // Per-channel scheduling state.
  typedef enum logic [1:0] {
    CH_FREE    = 2'd0,
    CH_OFFERED = 2'd1,
    CH_BUSY    = 2'd2
  } chan_sched_state_t;

endpackage

// File: rtl/channel_scheduler_rr_pick.sv
// Wrap-around first-set search: finds the first eligible consumer at or
// above the start pointer, wrapping modulo NUM_CONSUMERS.
module rr_pick #(
  parameter int NUM_CONSUMERS = 8,
  parameter int CID_BITS      = 3
) (
  input  logic [NUM_CONSUMERS-1:0] eligible,
  input  logic [CID_BITS-1:0]      start,
  output logic                     found,
  output logic [CID_BITS-1:0]      index
);

  // Scan upward from start; the first hit wins.
  always_comb begin
    logic [CID_BITS:0] pos;
    found = 1'b0;
    index = '0;
    pos   = '0;
    for (int unsigned i = 0; i < NUM_CONSUMERS; i++) begin
      pos = {1'b0, start} + (CID_BITS+1)'(i);
      if (pos >= (CID_BITS+1)'(NUM_CONSUMERS))
        pos = pos - (CID_BITS+1)'(NUM_CONSUMERS);
      if (!found && eligible[pos[CID_BITS-1:0]]) begin
        found = 1'b1;
        index = pos[CID_BITS-1:0];
      end
    end
  end

endmodule

// File: rtl/channel_scheduler.sv
// Channel scheduler: hands pending consumer requests to free memory
// channels round-robin, tracks offer/busy ownership per channel.
module channel_scheduler
  import channel_scheduler_pkg::*;
#(
  parameter int NUM_CONSUMERS = 8,
  parameter int NUM_CHANNELS  = 4,
  parameter int CID_BITS      = $clog2(NUM_CONSUMERS)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_CONSUMERS-1:0]         req_read_valid,
  input  logic [NUM_CONSUMERS-1:0]         req_write_valid,
  output logic [NUM_CONSUMERS-1:0]         consumer_claimed,
  output logic [NUM_CHANNELS-1:0]          assign_valid,
  output logic [NUM_CHANNELS*CID_BITS-1:0] assign_consumer,
  output logic [NUM_CHANNELS-1:0]          assign_write,
  input  logic [NUM_CHANNELS-1:0]          assign_ready,
  input  logic [NUM_CHANNELS-1:0]          chan_done,
  output logic [NUM_CHANNELS-1:0]          chan_busy
);

  chan_sched_state_t state_q [NUM_CHANNELS];
  chan_sched_state_t state_d [NUM_CHANNELS];
  logic [CID_BITS-1:0] owner_q [NUM_CHANNELS];
  logic [CID_BITS-1:0] owner_d [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] write_q, write_d;
  logic [CID_BITS-1:0] rr_ptr_q, rr_ptr_d;

  logic [NUM_CONSUMERS-1:0] released;
  logic [NUM_CONSUMERS-1:0] eligible;
  logic [NUM_CHANNELS-1:0]  found;
  logic [NUM_CHANNELS-1:0][CID_BITS-1:0] pick_idx;

  // Ownership decode, release detection and per-channel outputs.
  always_comb begin
    consumer_claimed = '0;
    released         = '0;
    assign_valid     = '0;
    assign_consumer  = '0;
    assign_write     = '0;
    chan_busy        = '0;
    for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
      if (state_q[c] != CH_FREE)
        consumer_claimed[owner_q[c]] = 1'b1;
      if (state_q[c] == CH_BUSY && chan_done[c])
        released[owner_q[c]] = 1'b1;
      if (state_q[c] == CH_OFFERED) begin
        assign_valid[c]                          = 1'b1;
        assign_consumer[c*CID_BITS +: CID_BITS]  = owner_q[c];
        assign_write[c]                          = write_q[c];
      end
      chan_busy[c] = (state_q[c] == CH_BUSY);
    end
  end

  assign eligible = (req_read_valid | req_write_valid) & ~consumer_claimed & ~released;

  // Each channel searches what earlier channels left over; the mask chain is
  // kept in per-iteration signals so it never loops through one vector.
  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
    logic [NUM_CONSUMERS-1:0] avail_in, avail_out, mask;
    logic                     pick_found;
    logic [CID_BITS-1:0]      pick_index;

    if (c == 0) begin : g_first
      assign avail_in = eligible;
    end else begin : g_rest
      assign avail_in = g_chan[c-1].avail_out;
    end

    assign mask = (state_q[c] == CH_FREE) ? avail_in : '0;

    rr_pick #(
      .NUM_CONSUMERS (NUM_CONSUMERS),
      .CID_BITS      (CID_BITS)
    ) u_pick (
      .eligible (mask),
      .start    (rr_ptr_q),
      .found    (pick_found),
      .index    (pick_index)
    );

    assign avail_out = pick_found ? (avail_in & ~(NUM_CONSUMERS'(1) << pick_index)) : avail_in;
    assign found[c]    = pick_found;
    assign pick_idx[c] = pick_index;
  end

  // Next-state: pick on FREE, accept on OFFERED, release on BUSY.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    write_d  = write_q;
    rr_ptr_d = rr_ptr_q;
    for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
      case (state_q[c])
        CH_FREE: begin
          if (found[c]) begin
            state_d[c] = CH_OFFERED;
            owner_d[c] = pick_idx[c];
            write_d[c] = !req_read_valid[pick_idx[c]];
            // Highest-index picking channel assigns last, so it sets the pointer.
            rr_ptr_d   = (pick_idx[c] == CID_BITS'(NUM_CONSUMERS-1)) ? '0
                                                                     : pick_idx[c] + CID_BITS'(1);
          end
        end
        CH_OFFERED: if (assign_ready[c]) state_d[c] = CH_BUSY;
        CH_BUSY:    if (chan_done[c])    state_d[c] = CH_FREE;
        default:    state_d[c] = CH_FREE;
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
        state_q[c] <= CH_FREE;
        owner_q[c] <= '0;
      end
      write_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      write_q  <= write_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule
